// File: rtl/hqc_harness_pkg.sv
// rtl/hqc_harness_pkg.sv - shared states and report characters for the HQC KEM harness sequencer
package hqc_harness_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SOFTRST,
        LOAD,
        RUN,
        STATUS,
        SSOUT,
        SEND_R
    } state_t;

    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_Y = 8'h59;
    localparam logic [7:0] CH_N = 8'h4E;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CH_T = 8'h54;

    function automatic logic [7:0] status_char(input logic ret0);
        return ret0 ? CH_N : CH_Y;
    endfunction

    function automatic logic reports_ss(input logic [7:0] stat);
        return (stat == CH_Y) || (stat == CH_N);
    endfunction

endpackage

// File: rtl/hqc_ss_capture.sv
// rtl/hqc_ss_capture.sv - shared-secret capture buffer with first-write-wins mask and core read port
module hqc_ss_capture #(
    parameter int SS_WORDS  = 8,
    parameter int SS_WORD_W = 64,
    parameter int SS_AW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 stop,
    input  logic [SS_AW-1:0]     ss_addr,
    input  logic                 ss_ce,
    input  logic                 ss_we,
    input  logic [SS_WORD_W-1:0] ss_d,
    output logic [SS_WORD_W-1:0] ss_q,
    input  logic [SS_AW-1:0]     rd_addr,
    output logic [SS_WORD_W-1:0] rd_word
);

    logic [SS_WORD_W-1:0] buf_q [SS_WORDS];
    logic [SS_WORD_W-1:0] buf_d [SS_WORDS];
    logic [SS_WORDS-1:0]  mask_q, mask_d;
    logic                 cap_en_q, cap_en_d;
    logic [SS_WORD_W-1:0] dout_q, dout_d;
    logic                 wr_en;

    // A word may only be captured once per run; a full mask closes the window early.
    always_comb begin
        mask_d   = mask_q;
        cap_en_d = cap_en_q;
        wr_en    = ss_ce && ss_we && cap_en_q && !mask_q[ss_addr];
        if (clr) begin
            mask_d   = '0;
            cap_en_d = 1'b0;
        end else begin
            if (wr_en) begin
                mask_d[ss_addr] = 1'b1;
            end
            if (start) begin
                cap_en_d = 1'b1;
            end
            if (stop || (&mask_d)) begin
                cap_en_d = 1'b0;
            end
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            buf_d[ss_addr] = ss_d;
        end
        dout_d = ss_ce ? buf_q[ss_addr] : dout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q    <= '{default: '0};
            mask_q   <= '0;
            cap_en_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            buf_q    <= buf_d;
            mask_q   <= mask_d;
            cap_en_q <= cap_en_d;
            dout_q   <= dout_d;
        end
    end

    assign ss_q    = dout_q;
    assign rd_word = buf_q[rd_addr];

endmodule

// File: rtl/hqc_kem_harness_ctrl.sv
// rtl/hqc_kem_harness_ctrl.sv - soft-reset, load, run and UART report sequencer for an HLS HQC KEM core
module hqc_kem_harness_ctrl
    import hqc_harness_pkg::*;
#(
    parameter int SS_WORDS     = 8,
    parameter int SS_WORD_W    = 64,
    parameter int SS_AW        = 3,
    parameter int SS_TX_BYTES  = 1,
    parameter int SOFT_RST_CYC = 1024,
    parameter int CORE_TIMEOUT = 2**26,
    parameter int TRIG_HOLD    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 soft_rst,
    output logic                 trig,
    output logic                 ld_start,
    input  logic                 ld_done,
    input  logic                 ld_success,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic [31:0]          core_ret,
    input  logic [SS_AW-1:0]     ss_addr,
    input  logic                 ss_ce,
    input  logic                 ss_we,
    input  logic [SS_WORD_W-1:0] ss_d,
    output logic [SS_WORD_W-1:0] ss_q,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy
);

    localparam int              BPW      = SS_WORD_W / 8;
    localparam int              BI_W     = (SS_TX_BYTES > 0) ? $clog2(SS_TX_BYTES + 1) : 1;
    localparam logic [BI_W-1:0] BI_LAST  = BI_W'((SS_TX_BYTES > 0) ? SS_TX_BYTES - 1 : 0);
    localparam logic [31:0]     SRC_LAST = 32'(SOFT_RST_CYC - 1);
    localparam logic [31:0]     WD_LAST  = 32'((CORE_TIMEOUT > 0) ? CORE_TIMEOUT - 1 : 0);

    state_t                state_q, state_d;
    logic [31:0]           cyc_q, cyc_d;
    logic [BI_W-1:0]       bidx_q, bidx_d;
    logic [7:0]            stat_q, stat_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_en_q, tx_en_d;
    logic                  trig_h_q, trig_h_d;

    logic                  can_send;
    logic                  run_done;
    logic                  wd_expire;
    logic                  cap_stop;
    logic [31:0]           bidx_ext;
    logic [SS_AW-1:0]      rd_addr;
    logic [SS_WORD_W-1:0]  rd_word;
    logic [7:0]            ss_byte;
    logic                  unused_ret;

    // The sender's busy flag rises a cycle after send_en, so never fire on back-to-back cycles.
    assign can_send   = !tx_busy && !tx_en_q;
    assign core_start = (state_q == LOAD) && ld_done && ld_success;
    assign run_done   = (state_q == RUN) && core_done;
    assign wd_expire  = (CORE_TIMEOUT > 0) && (state_q == RUN) && !core_done && (cyc_q == WD_LAST);
    assign cap_stop   = run_done || wd_expire;

    assign soft_rst   = (state_q == SOFTRST);
    assign ld_start   = (state_q == LOAD);
    assign trig       = core_start || ((TRIG_HOLD != 0) && trig_h_q);
    assign tx_en      = tx_en_q;
    assign tx_data    = tx_data_q;
    assign unused_ret = ^core_ret[31:1];

    assign bidx_ext = 32'(bidx_q);
    assign rd_addr  = SS_AW'(bidx_ext / 32'(BPW));
    assign ss_byte  = 8'(rd_word >> ((bidx_ext % 32'(BPW)) * 32'd8));

    hqc_ss_capture #(
        .SS_WORDS  (SS_WORDS),
        .SS_WORD_W (SS_WORD_W),
        .SS_AW     (SS_AW)
    ) u_cap (
        .clk     (clk),
        .rst     (rst),
        .clr     (soft_rst),
        .start   (core_start),
        .stop    (cap_stop),
        .ss_addr (ss_addr),
        .ss_ce   (ss_ce),
        .ss_we   (ss_we),
        .ss_d    (ss_d),
        .ss_q    (ss_q),
        .rd_addr (rd_addr),
        .rd_word (rd_word)
    );

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        bidx_d    = bidx_q;
        stat_d    = stat_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        trig_h_d  = trig_h_q;
        unique case (state_q)
            IDLE, SEND_R: begin
                if (can_send) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = CH_R;
                    cyc_d     = '0;
                    state_d   = SOFTRST;
                end
            end
            SOFTRST: begin
                if (cyc_q == SRC_LAST) begin
                    cyc_d   = '0;
                    state_d = LOAD;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            LOAD: begin
                if (ld_done) begin
                    if (ld_success) begin
                        cyc_d    = '0;
                        trig_h_d = 1'b1;
                        state_d  = RUN;
                    end else begin
                        stat_d  = CH_E;
                        state_d = STATUS;
                    end
                end
            end
            RUN: begin
                if (run_done) begin
                    stat_d   = status_char(core_ret[0]);
                    trig_h_d = 1'b0;
                    state_d  = STATUS;
                end else if (wd_expire) begin
                    stat_d   = CH_T;
                    trig_h_d = 1'b0;
                    state_d  = STATUS;
                end else begin
                    cyc_d = cyc_q + 32'd1;
                end
            end
            STATUS: begin
                if (can_send) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = stat_q;
                    bidx_d    = '0;
                    state_d   = (reports_ss(stat_q) && (SS_TX_BYTES > 0)) ? SSOUT : SEND_R;
                end
            end
            SSOUT: begin
                if (can_send) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = ss_byte;
                    if (bidx_q == BI_LAST) begin
                        state_d = SEND_R;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            bidx_q    <= '0;
            stat_q    <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            trig_h_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bidx_q    <= bidx_d;
            stat_q    <= stat_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            trig_h_q  <= trig_h_d;
        end
    end

endmodule
